// File: rtl/regfile_bank.sv
// regfile_bank: parametrised bank of NUM_REGS x DATA_WIDTH registers behind the
// reg_en/reg_we bus. Each register is RW, RO (hardware-driven), W1C (sticky status
// set by hw_set rising edges) or WTRIG (single-cycle pulse).
//
// Optional feature macro: REGBANK_IRQ_EN adds the irq output. irq is the OR of all
// W1C status bits ANDed with the RW mask register at IRQ_MASK_IDX.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   reg_en, reg_we      bus strobe and write select
//   reg_addr, reg_wdata byte address and write data
//   reg_rdata           read data, updated only on reads
//   reg_rvalid          one-cycle read-data strobe
//   reg_err             one-cycle strobe for an unmapped or misaligned access
//   reg_q               register contents to the core (RO slices read as 0)
//   hw_rdata            values returned on reads of RO registers
//   hw_set              level inputs; a rising edge sets the matching W1C bit
//   wr_pulse            per-register strobe, coincident with the bus update
//   irq                 interrupt (REGBANK_IRQ_EN only)
module regfile_bank #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_LSB   = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [2*NUM_REGS-1:0] REG_MODE = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter int IRQ_MASK_IDX = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reg_en,
  input  logic                           reg_we,
  input  logic [ADDR_WIDTH-1:0]          reg_addr,
  input  logic [DATA_WIDTH-1:0]          reg_wdata,
  output logic [DATA_WIDTH-1:0]          reg_rdata,
  output logic                           reg_rvalid,
  output logic                           reg_err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_pulse
`ifdef REGBANK_IRQ_EN
  ,
  output logic                           irq
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;
  localparam logic [1:0] MODE_WTRIG = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  logic [DATA_WIDTH-1:0] q [NUM_REGS];

  // address decode on the live request
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] off_idx;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  assign off     = reg_addr - BASE_ADDR;
  assign off_idx = off >> ADDR_LSB;
  assign dec_idx = off_idx[IDX_W-1:0];
  assign dec_hit = ((off & LSB_MASK) == '0) && (off_idx < ADDR_WIDTH'(NUM_REGS));

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_idx == IDX_W'(i)) begin
        case (REG_MODE[2*i +: 2])
          MODE_RO:    rd_val = hw_rdata[i*DATA_WIDTH +: DATA_WIDTH];
          MODE_WTRIG: rd_val = '0;
          default:    rd_val = q[i];
        endcase
      end
    end
  end

  // stage 1: write request held one cycle before it commits
  logic                  s1_wr;
  logic [IDX_W-1:0]      s1_idx;
  logic [DATA_WIDTH-1:0] s1_wdata;
  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_dly;
  logic [NUM_REGS*DATA_WIDTH-1:0] set_rise;

  assign set_rise = hw_set & ~hw_set_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_wr      <= 1'b0;
      s1_idx     <= '0;
      s1_wdata   <= '0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      reg_err    <= 1'b0;
      wr_pulse   <= '0;
      hw_set_dly <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        q[i] <= (REG_MODE[2*i +: 2] == MODE_RW) ? RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end else begin
      // a missed write is dropped here so it can never reach the commit stage
      s1_wr      <= reg_en & reg_we & dec_hit;
      s1_idx     <= dec_idx;
      s1_wdata   <= reg_wdata;
      reg_rvalid <= reg_en & ~reg_we;
      reg_err    <= reg_en & ~dec_hit;
      hw_set_dly <= hw_set;
      if (reg_en && !reg_we)
        reg_rdata <= dec_hit ? rd_val : '0;

      for (int i = 0; i < NUM_REGS; i++) begin
        logic                  wr_hit;
        logic [DATA_WIDTH-1:0] clr;
        wr_hit      = s1_wr && (s1_idx == IDX_W'(i));
        clr         = wr_hit ? s1_wdata : '0;
        wr_pulse[i] <= wr_hit;
        case (REG_MODE[2*i +: 2])
          MODE_RW:    if (wr_hit) q[i] <= s1_wdata;
          MODE_RO:    q[i] <= '0;
          // set is ORed in after the clear so a coincident edge wins
          MODE_W1C:   q[i] <= (q[i] & ~clr) | set_rise[i*DATA_WIDTH +: DATA_WIDTH];
          MODE_WTRIG: q[i] <= clr;
          default:    q[i] <= q[i];
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q[i];
  end

`ifdef REGBANK_IRQ_EN
  if (REG_MODE[2*IRQ_MASK_IDX +: 2] != MODE_RW) begin : g_mask_check
    $error("regfile_bank: IRQ_MASK_IDX must select an RW register");
  end

  logic [DATA_WIDTH-1:0] status_any;

  always_comb begin
    status_any = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (REG_MODE[2*i +: 2] == MODE_W1C)
        status_any = status_any | q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(status_any & q[IRQ_MASK_IDX]);
  end
`endif

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              reg_en = 1'b0;
  logic              reg_we = 1'b0;
  logic [AW-1:0]     reg_addr = '0;
  logic [DW-1:0]     reg_wdata = '0;
  logic [DW-1:0]     reg_rdata;
  logic              reg_rvalid;
  logic              reg_err;
  logic [NR*DW-1:0]  reg_q;
  logic [NR*DW-1:0]  hw_rdata = '0;
  logic [NR*DW-1:0]  hw_set = '0;
  logic [NR-1:0]     wr_pulse;
`ifdef REGBANK_IRQ_EN
  logic              irq;
`endif

  int total = 0;
  int bad = 0;

  regfile_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_LSB(2),
    .BASE_ADDR(32'h0), .REG_MODE(8'hE4), .RESET_VAL(128'hA5), .IRQ_MASK_IDX(0)
  ) dut (
    .clk(clk), .reset(reset), .reg_en(reg_en), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .reg_err(reg_err), .reg_q(reg_q),
    .hw_rdata(hw_rdata), .hw_set(hw_set), .wr_pulse(wr_pulse)
`ifdef REGBANK_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one transfer after a falling edge; returns on the next falling edge,
  // by which point the read/err response from that transfer is visible
  task automatic bus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    reg_en = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = data;
    @(negedge clk);
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    // 1. reset state, RW read/write, latency, pre-write read
    repeat (3) @(negedge clk);
    chk("rst_q", reg_q, 128'hA5);
    chk("rst_rvalid", reg_rvalid, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    reset = 1'b0;
    bus(0, 32'h0, 0);
    chk("rd0_rdata", reg_rdata, 32'hA5);
    chk("rd0_rvalid", reg_rvalid, 1);
    chk("rd0_err", reg_err, 0);
    @(negedge clk);
    chk("rd0_rvalid_drop", reg_rvalid, 0);
    chk("rd0_rdata_hold", reg_rdata, 32'hA5);
    bus(1, 32'h0, 32'h1234);
    chk("wr0_q_t1", reg_q[31:0], 32'hA5);
    chk("wr0_pulse_t1", wr_pulse, 4'b0000);
    @(negedge clk);
    chk("wr0_q_t2", reg_q[31:0], 32'h1234);
    chk("wr0_pulse_t2", wr_pulse, 4'b0001);
    @(negedge clk);
    chk("wr0_pulse_t3", wr_pulse, 4'b0000);
    bus(0, 32'h0, 0);
    chk("rd0_after_wr", reg_rdata, 32'h1234);
    // back-to-back write then read of the same register
    @(negedge clk);
    reg_en = 1; reg_we = 1; reg_addr = 32'h0; reg_wdata = 32'h55;
    @(negedge clk);
    reg_we = 0;
    @(negedge clk);
    reg_en = 0;
    chk("prewrite_rdata", reg_rdata, 32'h1234);
    chk("prewrite_q", reg_q[31:0], 32'h55);

    // 2. W1C set, set-beats-clear, clear
    hw_set[2*32+3] = 1'b1;
    @(negedge clk);
    chk("w1c_set", reg_q[95:64], 32'h8);
    hw_set[2*32+3] = 1'b0;
    @(negedge clk);
    bus(1, 32'h8, 32'h8);
    hw_set[2*32+3] = 1'b1;
    @(negedge clk);
    chk("w1c_set_wins", reg_q[95:64], 32'h8);
    chk("w1c_pulse", wr_pulse, 4'b0100);
    bus(1, 32'h8, 32'h8);
    @(negedge clk);
    chk("w1c_clear", reg_q[95:64], 32'h0);
    hw_set[2*32+3] = 1'b0;

    // 3. WTRIG pulse
    bus(1, 32'hC, 32'h5);
    chk("wtrig_t1", reg_q[127:96], 32'h0);
    @(negedge clk);
    chk("wtrig_t2", reg_q[127:96], 32'h5);
    chk("wtrig_pulse", wr_pulse, 4'b1000);
    @(negedge clk);
    chk("wtrig_t3", reg_q[127:96], 32'h0);
    bus(0, 32'h0, 0);
    chk("rd0_before_wtrig_rd", reg_rdata, 32'h55);
    bus(0, 32'hC, 0);
    chk("wtrig_rd", reg_rdata, 32'h0);

    // 4. address errors
    bus(0, 32'h0, 0);
    bus(1, 32'h10, 32'hFFFF_FFFF);
    chk("miss_wr_err", reg_err, 1);
    chk("miss_wr_rvalid", reg_rvalid, 0);
    @(negedge clk);
    chk("miss_wr_pulse", wr_pulse, 4'b0000);
    chk("miss_wr_q", reg_q, 128'h55);
    @(negedge clk);
    chk("miss_err_drop", reg_err, 0);
    bus(1, 32'h2, 32'hFFFF_FFFF);
    chk("misalign_err", reg_err, 1);
    @(negedge clk);
    chk("misalign_pulse", wr_pulse, 4'b0000);
    chk("misalign_q", reg_q, 128'h55);
    bus(0, 32'h10, 0);
    chk("miss_rd_rdata", reg_rdata, 32'h0);
    chk("miss_rd_rvalid", reg_rvalid, 1);
    chk("miss_rd_err", reg_err, 1);

    // 5. RO register, reset during an in-flight write
    hw_rdata[63:32] = 32'hDEAD;
    bus(1, 32'h4, 32'hFFFF);
    @(negedge clk);
    chk("ro_pulse", wr_pulse, 4'b0010);
    chk("ro_q", reg_q[63:32], 32'h0);
    bus(0, 32'h4, 0);
    chk("ro_rd", reg_rdata, 32'hDEAD);
    bus(1, 32'h0, 32'h77);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_inflight_q", reg_q[31:0], 32'hA5);
    chk("rst_inflight_pulse", wr_pulse, 4'b0000);
    chk("rst_rdata", reg_rdata, 32'h0);
    hw_set[2*32+0] = 1'b1;
    @(negedge clk);
    chk("rst_hold_w1c", reg_q[95:64], 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("hwset_across_rst", reg_q[95:64], 32'h1);
    hw_set[2*32+0] = 1'b0;

`ifdef REGBANK_IRQ_EN
    // 6. interrupt: reg2 bit0 already set; mask bit3 first, then raise bit3
    chk("irq_masked_off", irq, 0);
    bus(1, 32'h0, 32'h8);
    @(negedge clk);
    hw_set[2*32+3] = 1'b1;
    @(negedge clk);
    chk("irq_status_set", reg_q[95:64], 32'h9);
    chk("irq_lag", irq, 0);
    @(negedge clk);
    chk("irq_on", irq, 1);
    bus(1, 32'h0, 32'h0);
    @(negedge clk);
    chk("irq_mask_cleared", reg_q[31:0], 32'h0);
    chk("irq_still_on", irq, 1);
    @(negedge clk);
    chk("irq_off", irq, 0);
    hw_set[2*32+3] = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
